bram_bank_loader: RTL
=====================

// Module: bram_bank_loader
// PURPOSE
//  Upstream feeder for parsing_top. Takes a valid/ready stream of 128-bit feature-map words and
//  writes them bank-major into the 16 input BRAM banks through the parser's i_ena/i_wea/i_addra/i_dia
//  write port. Once every bank is full, it waits a fixed gap and then pulses the parser's iStart.
// PARAMETERS
//  NUM_BANK  16   number of BRAM banks; one-hot enable width
//  DATA_W    128  write data width (16 x 8-bit pixels)
//  ADDR_W    9    BRAM address width
//  DEPTH     128  words written per bank (addresses 0..DEPTH-1)
//  GAP       10   idle cycles between the last write and o_start
// PORTS
//  clk        in   1         clock; all logic on rising edge
//  rst        in   1         asynchronous, active-high reset
//  i_load     in   1         1-cycle pulse; starts a full load (ignored unless IDLE)
//  i_tvalid   in   1         input word valid
//  o_tready   out  1         loader can accept a word
//  i_tdata    in   DATA_W    input word
//  i_tlast    in   1         marks the final word (bank NUM_BANK-1, addr DEPTH-1)
//  o_ena      out  NUM_BANK  one-hot bank enable  -> parsing_top.i_ena
//  o_wea      out  NUM_BANK  one-hot write enable -> parsing_top.i_wea
//  o_addra    out  ADDR_W    write address        -> parsing_top.i_addra
//  o_dia      out  DATA_W    write data           -> parsing_top.i_dia
//  o_start    out  1         1-cycle start pulse  -> parsing_top.iStart
//  o_busy     out  1         high in every state except IDLE
//  o_done     out  1         1-cycle pulse when a load completes successfully
//  o_err      out  1         sticky i_tlast mismatch flag
// BEHAVIOUR
//  Reset: FSM=IDLE, bank/addr counters=0. o_ena, o_wea, o_addra, o_dia, o_tready, o_start, o_busy,
//   o_done and o_err all =0. A reset mid-load aborts at once and leaves no partial start.
//  FSM: IDLE -(i_load)-> LOAD -(final beat accepted)-> WAIT -(GAP cycles)-> START (1 cycle) -> IDLE.
//   Any abort returns to IDLE.
//  i_load in IDLE clears o_err and zeroes both counters. i_load in any other state is ignored.
//  o_tready =1 only in LOAD. A beat is accepted when i_tvalid && o_tready. Stalls (i_tvalid=0) are
//   allowed anywhere and insert idle cycles (o_ena=0).
//  Write latency is 1 cycle, and all write outputs are registered. For a beat accepted in cycle N,
//   in cycle N+1: o_ena = o_wea = 1<<bank, o_addra = addr, o_dia = i_tdata.
//   In cycles with no accepted beat, o_ena = o_wea = 0 and o_addra/o_dia hold their last values.
//  Counters: addr increments per beat. When addr = DEPTH-1, addr wraps to 0 and bank increments.
//   The final beat is bank = NUM_BANK-1, addr = DEPTH-1. Total beats = NUM_BANK*DEPTH = 2048.
//  tlast check:
//   - i_tlast=1 on a non-final beat, or i_tlast=0 on the final beat: that beat is still written,
//     then o_err<=1, FSM returns to IDLE, and there is no o_start and no o_done.
//  WAIT: o_ena=0 for exactly GAP cycles, counted from the cycle after the final write is presented.
//   If the final beat is accepted in cycle T: write at T+1, WAIT covers T+2..T+1+GAP,
//   o_start=1 and o_done=1 in cycle T+2+GAP, and FSM is IDLE at T+3+GAP.
//  o_busy = (FSM != IDLE). o_err holds until the next accepted i_load or rst.
// TESTING
//  1 Full load, i_tvalid always 1, data = {16{bank[7:0]}} -> 2048 writes; o_ena 0x0001..0x8000 in order;
//    o_addra 0..127 per bank; o_start is a single 1-cycle pulse 12 cycles after the final accepted beat.
//  2 Random i_tvalid gaps (~30% idle) -> same write sequence, no writes during idle cycles, o_err=0.
//  3 i_tlast=1 on beat 100 (bank 0, addr 100) -> that write occurs; then o_err=1, o_tready=0,
//    no o_start, o_busy=0.
//  4 i_tlast=0 on beat 2047 -> write to bank 15 addr 127 occurs; o_err=1; no o_start.
//  5 rst asserted during bank 7 -> all outputs 0 immediately; a new i_load reloads from bank 0 addr 0.
//  6 i_load pulsed during LOAD and during WAIT -> ignored; counters and o_start timing unchanged.

Source files
------------

// File: rtl/bram_bank_loader.sv
// Streams 128-bit feature-map words bank-major into the parser's input BRAM banks,
// then waits a fixed gap and pulses the parser's start input.
module bram_bank_loader #(
  parameter int NUM_BANK = 16,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 9,
  parameter int DEPTH    = 128,
  parameter int GAP      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_tvalid,
  output logic                o_tready,
  input  logic [DATA_W-1:0]   i_tdata,
  input  logic                i_tlast,
  output logic [NUM_BANK-1:0] o_ena,
  output logic [NUM_BANK-1:0] o_wea,
  output logic [ADDR_W-1:0]   o_addra,
  output logic [DATA_W-1:0]   o_dia,
  output logic                o_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int GAP_W  = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    START
  } state_t;

  state_t              state;
  logic [BANK_W-1:0]   bank;
  logic [ADDR_W-1:0]   addr;
  logic [GAP_W-1:0]    gapCnt;

  logic accept;
  logic lastAddr;
  logic finalBeat;

  // o_tready is registered and high exactly while in LOAD.
  assign accept    = i_tvalid && o_tready;
  assign lastAddr  = (addr == ADDR_W'(DEPTH - 1));
  assign finalBeat = lastAddr && (bank == BANK_W'(NUM_BANK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bank     <= '0;
      addr     <= '0;
      gapCnt   <= '0;
      o_tready <= 1'b0;
      o_ena    <= '0;
      o_wea    <= '0;
      o_addra  <= '0;
      o_dia    <= '0;
      o_start  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the
      // pre-edge values of state/bank/addr regardless of statement order.
      o_ena   <= '0;
      o_wea   <= '0;
      o_start <= 1'b0;
      o_done  <= 1'b0;

      // Write port mirrors the accepted beat one cycle later; address/data hold otherwise.
      if (accept) begin
        o_ena   <= NUM_BANK'(1) << bank;
        o_wea   <= NUM_BANK'(1) << bank;
        o_addra <= addr;
        o_dia   <= i_tdata;
      end

      case (state)
        IDLE: begin
          if (i_load) begin
            state    <= LOAD;
            bank     <= '0;
            addr     <= '0;
            o_err    <= 1'b0;
            o_tready <= 1'b1;
            o_busy   <= 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            if (lastAddr) begin
              addr <= '0;
              bank <= bank + 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end

            // A misplaced i_tlast still writes its beat, then aborts the load.
            if (i_tlast != finalBeat) begin
              state    <= IDLE;
              o_err    <= 1'b1;
              o_tready <= 1'b0;
              o_busy   <= 1'b0;
            end else if (finalBeat) begin
              state    <= WAIT;
              gapCnt   <= '0;
              o_tready <= 1'b0;
            end
          end
        end

        // WAIT is entered on the final write cycle; GAP empty cycles follow it.
        WAIT: begin
          if (gapCnt == GAP_W'(GAP)) begin
            state   <= START;
            o_start <= 1'b1;
            o_done  <= 1'b1;
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end

        START: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          o_tready <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
